// File: rtl/bit_divider_8_pkg.sv
// Shared types and constants for the sequential restoring divider.
package divider_pkg;

  localparam int DIV_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    STEP = 2'd2,
    DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/bit_divider_8_reg_rq.sv
// Partial-remainder / quotient shift register with the restoring subtract step.
module reg_RQ #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   r,
  output logic [WIDTH-1:0] q,
  output logic             diff_neg
);

  logic [WIDTH:0] t_r;
  logic [WIDTH:0] diff;

  // R's MSB is always 0 between steps (R < D), so shifting it out loses nothing.
  assign t_r      = {r[WIDTH-1:0], q[WIDTH-1]};
  assign diff     = t_r - {1'b0, divisor};
  assign diff_neg = diff[WIDTH];

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r <= '0;
      q <= '0;
    end else if (load) begin
      r <= '0;
      q <= dividend;
    end else if (shift) begin
      if (!diff_neg) begin
        r <= diff;
        q <= {q[WIDTH-2:0], 1'b1};
      end else begin
        r <= t_r;
        q <= {q[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/bit_divider_8.sv
// Unsigned restoring divider: one shift-subtract step per clock, WIDTH steps per result.
//
// state | meaning
// IDLE  | waiting for Run; outputs keep the last result
// LOAD  | latch Dividend/Divisor, clear remainder and step counter
// STEP  | one shift-subtract per cycle, WIDTH cycles
// DONE  | result valid; wait for Run to drop before re-arming
module bit_divider_8
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  div_state_t state, state_next;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] d;
  logic [WIDTH:0]   r;
  logic [WIDTH-1:0] q;
  logic             diff_neg;
  logic             load_en;
  logic             step_en;
  logic             unused_bits;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (Run) state_next = LOAD;
      LOAD: state_next = STEP;
      STEP: if (cnt == CNT_LAST) state_next = DONE;
      DONE: if (!Run) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    load_en = 1'b0;
    step_en = 1'b0;
    Busy    = 1'b0;
    Done    = 1'b0;
    case (state)
      LOAD: begin
        load_en = 1'b1;
        Busy    = 1'b1;
      end
      STEP: begin
        step_en = 1'b1;
        Busy    = 1'b1;
      end
      DONE:    Done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt       <= '0;
      d         <= '0;
      DivByZero <= 1'b0;
    end else if (load_en) begin
      cnt       <= '0;
      d         <= Divisor;
      DivByZero <= (Divisor == '0);
    end else if (step_en) begin
      cnt <= cnt + CW'(1);
    end
  end

  reg_RQ #(.WIDTH(WIDTH)) u_reg_rq (
    .Clk      (Clk),
    .Reset    (Reset),
    .load     (load_en),
    .shift    (step_en),
    .dividend (Dividend),
    .divisor  (d),
    .r        (r),
    .q        (q),
    .diff_neg (diff_neg)
  );

  assign Quotient    = q;
  assign Remainder   = r[WIDTH-1:0];
  assign unused_bits = ^{r[WIDTH], diff_neg};

endmodule

// File: doc/bit_divider_8.md
# bit_divider_8

Sequential unsigned shift-subtract (restoring) divider: the inverse datapath of the 8-bit shift-add multiplier. It computes an 8-bit quotient and an 8-bit remainder using one shift-subtract step per clock. It sits beside the multiplier in the arithmetic lab top level and is driven by the same Run/switch inputs, with results shown on the same hex displays.

## Interface
- WIDTH, 8, operand, quotient and remainder width. The tests cover only 8, but the RTL must not hard-code 8.
- Clk  input  1  system clock; all state changes on its rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Run  input  1  start request, level-sensitive, already synchronized and debounced upstream.
- Dividend  input  WIDTH  unsigned dividend, sampled in LOAD.
- Divisor  input  WIDTH  unsigned divisor, sampled in LOAD.
- Quotient  output  WIDTH  result quotient.
- Remainder  output  WIDTH  result remainder.
- Busy  output  1  high in LOAD and STEP.
- Done  output  1  high in DONE.
- DivByZero  output  1  set when the sampled Divisor was 0; valid while Done is high and afterwards, until the next LOAD.

## Operation
- Datapath registers:
  - R: WIDTH+1 bits, partial remainder.
  - Q: WIDTH bits, dividend shifting into quotient.
  - D: WIDTH bits, latched divisor.
  - cnt: $clog2(WIDTH+1) bits.
- FSM states: IDLE, LOAD, STEP, DONE.
- IDLE:
  - If Run is 1, go to LOAD.
  - Registers hold, so the outputs keep showing the last result.
- LOAD (1 cycle):
  - R ← 0, Q ← Dividend, D ← Divisor, cnt ← 0.
  - DivByZero ← (Divisor == 0).
  - Next state is STEP.
- STEP (exactly WIDTH cycles). Each cycle:
  - {R,Q} is shifted left 1 into a temporary value t.
  - diff = t_R − {1'b0,D}, computed at WIDTH+1 bits.
  - If diff[WIDTH] == 0: R ← diff, Q ← {t_Q[WIDTH-1:1], 1}.
  - Otherwise: R ← t_R, Q ← {t_Q[WIDTH-1:1], 0}.
  - cnt increments. When cnt == WIDTH−1, the next state is DONE.
- DONE:
  - Stay while Run is 1. Go to IDLE when Run is 0, so a held Run never re-triggers.
- Outputs: Quotient = Q, Remainder = R[WIDTH-1:0]. R[WIDTH] is always 0 at DONE.
- Divide by zero:
  - No special path. The full WIDTH steps still run and naturally give Quotient = all ones and Remainder = Dividend.
  - DivByZero = 1 marks the result as invalid.
- Inputs that change during STEP are ignored, because D and Q were latched in LOAD.

## Timing
- Reset asserted (at any time, including mid-STEP):
  - State goes to IDLE immediately.
  - R, Q, D, cnt and DivByZero go to 0.
  - Outputs: Quotient = 0, Remainder = 0, Busy = 0, Done = 0, DivByZero = 0.
- After reset is released, the first rising edge with Run = 1 moves to LOAD.
- Latency, with edge 0 being the edge where IDLE samples Run = 1:
  - LOAD occupies the cycle after edge 0.
  - STEP occupies the cycles after edges 1 through WIDTH.
  - Done rises after edge WIDTH+1, which is edge 9 for WIDTH = 8. Quotient and Remainder are final in that same cycle.
- Busy is high exactly WIDTH+1 cycles per operation. Busy and Done are never high together.
- Run dropping during LOAD or STEP is ignored; the operation completes.
- If Run is 0 in DONE, the next cycle is IDLE. If Run is 1 again in that IDLE cycle, LOAD follows one cycle later, so the minimum spacing between starts is WIDTH+3 cycles.

## Structure
- Package divider_pkg contains:
  - typedef enum logic [1:0] {IDLE, LOAD, STEP, DONE} div_state_t;
  - localparam DIV_WIDTH = 8.
- Sub-module reg_RQ: the WIDTH+1 + WIDTH bit R/Q register with load and shift-subtract enables. It contains the subtractor and restore mux, and exposes R, Q and the diff sign.
- The top level contains the FSM, cnt, the D register and the DivByZero flag.

## Test plan
- Reset low, then high. Check all outputs are 0 and Busy = 0. Then drive Dividend = 100, Divisor = 7, Run = 1: Done rises at edge 9 with Quotient = 14, Remainder = 2, DivByZero = 0.
- Dividend = 255, Divisor = 1: Quotient = 255, Remainder = 0. Dividend = 5, Divisor = 9: Quotient = 0, Remainder = 5. Dividend = 255, Divisor = 255: Quotient = 1, Remainder = 0.
- Dividend = 200, Divisor = 0: Quotient = 8'hFF, Remainder = 200, DivByZero = 1. A following run with 10 / 3 clears DivByZero and gives Quotient = 3, Remainder = 1.
- Start 100 / 7, then change Dividend to 50 and Divisor to 3 during STEP: result is still Quotient = 14, Remainder = 2.
- Assert Reset at edge 5 of an operation: state is IDLE, all outputs are 0, and Busy drops immediately. After release, a new 100 / 7 run completes normally at edge 9.
- Hold Run = 1 for 20 cycles after Done: Done stays high and Busy stays 0. Drop Run for 1 cycle, then raise it: a new operation completes 9 edges after the restart edge.
